// File: rtl/toy_regfile_sb.sv
// toy_regfile_sb
// General-purpose register file with a per-register pending-write scoreboard.
// The ID stage reads operands and issues instructions. The WB stage writes
// results back. Each register has a counter of in-flight writes. A read of a
// register with outstanding writes raises stall, and so does an issue to a
// register whose counter is saturated.
//
// Ports:
//   CLK, RSTN          clock (rising edge), asynchronous active-low reset
//   rd_en/rd_addr      NRD read ports; port i address at [i*AW +: AW]
//   rd_data            combinational read data; port i at [i*DW +: DW]
//   iss_valid/iss_wr   ID presents an instruction; it writes iss_dest
//   iss_dest           destination register of the presented instruction
//   stall              combinational; the issue is not accepted this cycle
//   wb_en/wb_addr/
//   wb_data            writeback port
//   flush              squashes all in-flight writes
//   pend_any           registered; some counter is nonzero
//   wb_err             sticky; writeback to a register with no pending write
//
// Optional feature macro: TOY_RF_BYPASS_EN
//   When defined, a writeback to a register is forwarded to a read of the
//   same register in the same cycle. If that writeback retires the last
//   pending write, the read does not stall.
module toy_regfile_sb #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int NRD = 2,
  parameter int CW  = 2
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic [NRD-1:0]    rd_en,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  input  logic              iss_valid,
  input  logic              iss_wr,
  input  logic [AW-1:0]     iss_dest,
  output logic              stall,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DW-1:0]     wb_data,
  input  logic              flush,
  output logic              pend_any,
  output logic              wb_err
);

  localparam int ENTRY = 2**AW;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [DW-1:0] regs_q [ENTRY];
  logic [CW-1:0] cnt_q  [ENTRY];
  logic [CW-1:0] cnt_d  [ENTRY];
  logic          pend_any_q, pend_any_d;
  logic          wb_err_q;
  logic          hit, full, acc;

  // Read ports and the RAW hazard check, both against pre-update state.
  always_comb begin
    rd_data = '0;
    hit     = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      logic resolved;
      resolved = 1'b0;
      rd_data[i*DW +: DW] = regs_q[rd_addr[i*AW +: AW]];
`ifdef TOY_RF_BYPASS_EN
      if (wb_en && (wb_addr == rd_addr[i*AW +: AW])) begin
        rd_data[i*DW +: DW] = wb_data;
        resolved = (cnt_q[rd_addr[i*AW +: AW]] == CW'(1));
      end
`endif
      if (rd_en[i] && (cnt_q[rd_addr[i*AW +: AW]] != '0) && !resolved)
        hit = 1'b1;
    end
  end

  // A saturated counter blocks the issue, so counters never wrap.
  assign full  = iss_valid && iss_wr && (cnt_q[iss_dest] == CNT_MAX);
  assign stall = iss_valid && (hit || full);
  assign acc   = iss_valid && iss_wr && !stall && !flush;

  always_comb begin
    pend_any_d = 1'b0;
    for (int r = 0; r < ENTRY; r++) begin
      logic inc, dec;
      inc = acc && (iss_dest == AW'(r));
      dec = wb_en && (wb_addr == AW'(r)) && (cnt_q[r] != '0);
      cnt_d[r] = cnt_q[r];
      if (flush)
        cnt_d[r] = '0;
      else if (inc && !dec)
        cnt_d[r] = cnt_q[r] + CW'(1);
      else if (dec && !inc)
        cnt_d[r] = cnt_q[r] - CW'(1);
      if (cnt_d[r] != '0)
        pend_any_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int r = 0; r < ENTRY; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      pend_any_q <= 1'b0;
      wb_err_q   <= 1'b0;
    end else begin
      if (wb_en)
        regs_q[wb_addr] <= wb_data;
      for (int r = 0; r < ENTRY; r++)
        cnt_q[r] <= cnt_d[r];
      pend_any_q <= pend_any_d;
      // A flush squashes the write's bookkeeping, so it cannot be an orphan.
      if (wb_en && !flush && (cnt_q[wb_addr] == '0))
        wb_err_q <= 1'b1;
    end
  end

  assign pend_any = pend_any_q;
  assign wb_err   = wb_err_q;

endmodule

// File: tb/tb_toy_regfile_sb.sv
module tb_toy_regfile_sb;

  localparam int DW = 32, AW = 5, NRD = 2, CW = 2;
  localparam int ENTRY = 32;
  localparam int MAXC = 3;

  logic              CLK = 1'b0;
  logic              RSTN;
  logic [NRD-1:0]    rd_en;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic              iss_valid, iss_wr;
  logic [AW-1:0]     iss_dest;
  logic              stall;
  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [DW-1:0]     wb_data;
  logic              flush;
  logic              pend_any, wb_err;

  toy_regfile_sb #(.DW(DW), .AW(AW), .NRD(NRD), .CW(CW)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_dest(iss_dest),
    .stall(stall),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .pend_any(pend_any), .wb_err(wb_err)
  );

  always #5 CLK = ~CLK;

  // Reference model: register contents, in-flight write counts, flags.
  logic [31:0] mreg [ENTRY];
  int          mcnt [ENTRY];
  logic        merr;

  int total = 0;
  int bad   = 0;

  // Snapshot of DUT outputs from the latest step, for literal checks.
  logic [31:0] obs_rd [NRD];
  logic        obs_stall, obs_pend, obs_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_pend();
    for (int r = 0; r < ENTRY; r++)
      if (mcnt[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < ENTRY; r++) begin
      mreg[r] = '0;
      mcnt[r] = 0;
    end
    merr = 1'b0;
  endtask

  task automatic idle();
    rd_en = '0; rd_addr = '0;
    iss_valid = 0; iss_wr = 0; iss_dest = '0;
    wb_en = 0; wb_addr = '0; wb_data = '0; flush = 0;
  endtask

  // One clock cycle: compare DUT against the model at the falling edge,
  // then advance the model across the rising edge.
  task automatic step();
    logic exp_stall, any_hit, exp_pend;
    @(negedge CLK);
    exp_pend = model_pend();
    any_hit = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      int a;
      logic [31:0] exp_rd;
      logic res;
      a = int'(rd_addr[i*AW +: AW]);
      exp_rd = mreg[a];
      res = 1'b0;
`ifdef TOY_RF_BYPASS_EN
      if (wb_en && (int'(wb_addr) == a)) begin
        exp_rd = wb_data;
        res = (mcnt[a] == 1);
      end
`endif
      if (rd_en[i] && mcnt[a] != 0 && !res) any_hit = 1'b1;
      chk($sformatf("rd_data%0d", i), rd_data[i*DW +: DW], exp_rd);
      obs_rd[i] = rd_data[i*DW +: DW];
    end
    exp_stall = iss_valid && (any_hit || (iss_wr && mcnt[iss_dest] == MAXC));
    chk("stall", stall, exp_stall);
    chk("pend_any", pend_any, exp_pend);
    chk("wb_err", wb_err, merr);
    obs_stall = stall; obs_pend = pend_any; obs_err = wb_err;
    @(posedge CLK);
    if (wb_en) mreg[wb_addr] = wb_data;
    if (flush) begin
      for (int r = 0; r < ENTRY; r++) mcnt[r] = 0;
    end else begin
      if (wb_en) begin
        if (mcnt[wb_addr] == 0) merr = 1'b1;
        else mcnt[wb_addr]--;
      end
      if (iss_valid && iss_wr && !exp_stall) mcnt[iss_dest]++;
    end
    #1;
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    idle();
    model_clear();
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input int d);
    idle(); iss_valid = 1; iss_wr = 1; iss_dest = AW'(d);
    step();
  endtask

  task automatic wb(input int d, input logic [31:0] v);
    idle(); wb_en = 1; wb_addr = AW'(d); wb_data = v;
    step();
  endtask

  initial begin
    RSTN = 1'b0;
    idle();
    model_clear();
    #12;
    do_reset();

    // 1: reset state
    rd_addr = {5'd31, 5'd3};
    step();
    chk("t1_rd0", obs_rd[0], 0);
    chk("t1_rd1", obs_rd[1], 0);
    chk("t1_stall", obs_stall, 0);
    chk("t1_pend", obs_pend, 0);
    chk("t1_err", obs_err, 0);

    // 2: RAW on r5
    issue(5);
    chk("t2_iss_stall", obs_stall, 0);
    idle(); iss_valid = 1; rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    step();
    chk("t2_raw_stall", obs_stall, 1);
    wb_en = 1; wb_addr = 5; wb_data = 32'hDEAD_BEEF;
    step();
`ifdef TOY_RF_BYPASS_EN
    chk("t2_wb_stall", obs_stall, 0);
    chk("t2_wb_rd", obs_rd[0], 32'hDEAD_BEEF);
`else
    chk("t2_wb_stall", obs_stall, 1);
`endif
    wb_en = 0;
    step();
    chk("t2_after_stall", obs_stall, 0);
    chk("t2_after_rd", obs_rd[0], 32'hDEAD_BEEF);

    // 3: counter saturation on r7
    repeat (3) issue(7);
    issue(7);
    chk("t3_full_stall", obs_stall, 1);
    wb(7, 32'h7); wb(7, 32'h77); wb(7, 32'h777);
    chk("t3_pend_last_wb", obs_pend, 1);
    idle(); step();
    chk("t3_pend_clear", obs_pend, 0);
    chk("t3_no_err", obs_err, 0);

    // 4: concurrent issue and writeback to r9
    issue(9);
    idle(); iss_valid = 1; iss_wr = 1; iss_dest = 9;
    wb_en = 1; wb_addr = 9; wb_data = 32'h0000_0099;
    step();
    chk("t4_iss_stall", obs_stall, 0);
    idle(); iss_valid = 1; rd_en = 2'b10; rd_addr = {5'd9, 5'd0};
    step();
    chk("t4_still_pending", obs_stall, 1);
    chk("t4_rd", obs_rd[1], 32'h99);
    wb(9, 32'h0000_0099);

    // 5: flush with concurrent writeback, then orphan writeback
    issue(2); issue(4);
    idle(); flush = 1; wb_en = 1; wb_addr = 2; wb_data = 32'h1234;
    step();
    idle(); iss_valid = 1; rd_en = 2'b11; rd_addr = {5'd4, 5'd2};
    step();
    chk("t5_rd", obs_rd[0], 32'h1234);
    chk("t5_stall", obs_stall, 0);
    chk("t5_pend", obs_pend, 0);
    chk("t5_err", obs_err, 0);
    wb(4, 32'h4444);
    idle(); step();
    chk("t5_err_set", obs_err, 1);

    // 6: asynchronous reset mid-operation
    wb(6, 32'h66);
    issue(6); issue(6);
    idle(); iss_valid = 1; rd_en = 2'b01; rd_addr = {5'd0, 5'd6};
    step();
    chk("t6_stall_before", obs_stall, 1);
    #2;
    chk("t6_stall_hold", stall, 1);
    RSTN = 1'b0;
    #1;
    chk("t6_stall_rst", stall, 0);
    chk("t6_pend_rst", pend_any, 0);
    chk("t6_err_rst", wb_err, 0);
    chk("t6_rd_rst", rd_data[DW-1:0], 0);
    do_reset();

    // Randomised traffic on a small register pool.
    for (int n = 0; n < 3000; n++) begin
      int pq[$];
      if (n % 600 == 599) do_reset();
      rd_en     = NRD'($urandom_range(0, 3));
      rd_addr   = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      iss_valid = ($urandom_range(0, 3) != 0);
      iss_wr    = ($urandom_range(0, 3) != 0);
      iss_dest  = AW'($urandom_range(0, 7));
      wb_en     = ($urandom_range(0, 9) < 4);
      for (int r = 0; r < ENTRY; r++)
        if (mcnt[r] != 0) pq.push_back(r);
      if (pq.size() != 0 && $urandom_range(0, 7) != 0)
        wb_addr = AW'(pq[$urandom_range(0, pq.size() - 1)]);
      else
        wb_addr = AW'($urandom_range(0, 7));
      wb_data = $urandom;
      flush   = ($urandom_range(0, 31) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/toy_regfile_sb.md
Name: toy_regfile_sb

Overview:
- Parametrised general-purpose register file with an integrated per-register pending-write scoreboard for the next-generation pipelined TOY core.
- Provides NRD combinational read ports and one writeback port.
- Counts in-flight writes per register and raises a stall when a decode-stage read or issue would hit an unresolved write.
- Sits between the ID stage (read/issue side) and the WB stage (write side), replacing the plain register file and adding RAW/WAW hazard detection.

Parameters:
- DW, 32, data width of each register
- AW, 5, register address width; ENTRY = 2**AW registers
- NRD, 2, number of read ports (1..4)
- CW, 2, width of each pending-write counter; max in-flight writes per register = 2**CW-1

Ports:
- CLK  input  1  clock, rising edge
- RSTN  input  1  asynchronous active-low reset
- rd_en  input  NRD  per-port read enable; only enabled ports participate in the hazard check
- rd_addr  input  NRD*AW  read addresses, port i at [i*AW +: AW]
- rd_data  output  NRD*DW  read data, port i at [i*DW +: DW], combinational
- iss_valid  input  1  ID stage presents an instruction this cycle
- iss_wr  input  1  presented instruction writes a destination register
- iss_dest  input  AW  destination register of the presented instruction
- stall  output  1  combinational; ID must hold, and the issue is not accepted
- wb_en  input  1  writeback strobe
- wb_addr  input  AW  writeback register
- wb_data  input  DW  writeback data
- flush  input  1  squash all in-flight writes (branch/jump taken)
- pend_any  output  1  registered; at least one counter is nonzero
- wb_err  output  1  sticky; writeback arrived for a register with counter 0

Behaviour:
Reset:
- All registers clear to 0; all counters clear to 0; pend_any = 0; wb_err = 0.
- stall evaluates to 0 after reset because all counters are 0.
- Reset asserted mid-operation discards all pending state immediately.

Write:
- On a CLK edge with wb_en = 1, reg[wb_addr] <= wb_data.
- Every register is writable; there is no hard-wired zero register.

Read:
- rd_data[i] = reg[rd_addr[i]], combinational, 0-cycle latency.

Hazard check (combinational):
- hit_i = rd_en[i] and cnt[rd_addr[i]] != 0 and not resolved_i.
- resolved_i is defined only under TOY_RF_BYPASS_EN; otherwise it is 0.
- full = iss_valid and iss_wr and cnt[iss_dest] == 2**CW-1.
- stall = iss_valid and (OR of hit_i, or full).

Issue acceptance:
- acc = iss_valid and iss_wr and not stall and not flush.

Counter update per register r, at each edge:
- flush = 1: all cnt <= 0. A wb_en in the same cycle still writes data but neither decrements nor sets wb_err.
- Otherwise:
  - inc = acc and iss_dest == r
  - dec = wb_en and wb_addr == r and cnt[r] != 0
  - inc and dec together: cnt unchanged
  - inc only: cnt + 1
  - dec only: cnt - 1
- Counters never wrap: the full condition blocks any increment at the maximum value.

Error flag:
- wb_err <= 1 when wb_en, not flush, and cnt[wb_addr] == 0.
- Cleared only by reset.

pend_any:
- Registered OR of all next-state counters; valid one cycle after the update.

Same-cycle events:
- An issue to r in the same cycle as a read of r by another port: the read is checked against the pre-update counter.

Optional Feature:
Macro TOY_RF_BYPASS_EN.
- Defined:
  - When wb_en = 1 and wb_addr == rd_addr[i], rd_data[i] = wb_data.
  - resolved_i = 1 when, in addition, cnt[rd_addr[i]] == 1. The final in-flight write lands this cycle, so no stall is needed.
- Not defined:
  - rd_data always comes from array storage.
  - A read of a register being written this cycle stalls one cycle longer and sees the new value next cycle.

Test Plan:
1. Reset, then read ports 0/1 at r3/r31 -> rd_data = 0/0, stall = 0, pend_any = 0, wb_err = 0.
2. Issue dest r5 (accepted), next cycle read r5 with rd_en = 1 -> stall = 1. wb r5 = 0xDEAD_BEEF -> with bypass, stall = 0 in the wb cycle and rd_data = 0xDEADBEEF; without bypass, stall = 0 one cycle later with the same data.
3. CW = 2: issue r7 three times with no wb -> cnt = 3; fourth issue to r7 -> stall = 1 and cnt stays 3. Three wbs -> cnt = 0, pend_any = 0 one cycle after the last.
4. Same cycle: issue r9 plus wb r9 with cnt[r9] = 1 -> cnt stays 1, reg[r9] updated.
5. Issue r2 and r4, then flush concurrent with wb r2 = 0x1234 -> all cnt = 0, reg[r2] = 0x1234, wb_err = 0. Later wb r4 -> wb_err = 1.
6. Assert RSTN low while cnt[r6] = 2 and stall = 1 -> stall, pend_any, wb_err and all registers return to 0 asynchronously.
